// File: rtl/dct_basis_streamer_pkg.sv
// Shared constants, FSM state type and the 1-D cosine ROM generator for the DCT basis streamer.
package dct_basis_streamer_pkg;

    localparam int  DCT_N        = 8;
    localparam int  DCT_COEF_W   = 16;
    localparam int  DCT_OUT_FRAC = 10;
    localparam int  DCT_OUT_W    = 32;
    localparam real DCT_PI       = 3.14159265358979323846;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // 0.5*C(k)*cos((2n+1)k*pi/2N) scaled by 2**(coef_w-2), truncated toward zero
    function automatic int cos1d_entry(input int k, input int n, input int nn, input int coef_w);
        real ck;
        real ang;
        real val;
        ck  = (k == 0) ? (1.0 / $sqrt(2.0)) : 1.0;
        ang = (real'((2 * n + 1) * k) * DCT_PI) / real'(2 * nn);
        val = 0.5 * ck * $cos(ang) * real'(64'd1 << (coef_w - 2));
        return $rtoi(val);
    endfunction

endpackage

// File: rtl/dct_basis_streamer_rom.sv
// Dual-read synchronous cosine ROM, one row per frequency k, filled at elaboration.
module dct_cos1d_rom
    import dct_basis_streamer_pkg::*;
#(
    parameter int N      = DCT_N,
    parameter int COEF_W = DCT_COEF_W
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic [$clog2(N)-1:0]   k1,
    input  logic [$clog2(N)-1:0]   n1,
    input  logic [$clog2(N)-1:0]   k2,
    input  logic [$clog2(N)-1:0]   n2,
    output logic [COEF_W-1:0]      c1,
    output logic [COEF_W-1:0]      c2
);

    logic [COEF_W-1:0] rom_s [N*N];

    for (genvar gk = 0; gk < N; gk++) begin : g_k
        for (genvar gn = 0; gn < N; gn++) begin : g_n
            localparam logic [COEF_W-1:0] ENTRY = COEF_W'(cos1d_entry(gk, gn, N, COEF_W));
            assign rom_s[gk*N+gn] = ENTRY;
        end
    end

    // registered reads; outputs hold while read enable is low
    always_ff @(posedge clk) begin
        if (reset) begin
            c1 <= {COEF_W{1'b0}};
            c2 <= {COEF_W{1'b0}};
        end else if (rd_en) begin
            c1 <= rom_s[{k1, n1}];
            c2 <= rom_s[{k2, n2}];
        end
    end

endmodule

// File: rtl/dct_basis_streamer.sv
// Streams the N*N 2-D DCT-II basis terms for one (k1,k2) pair, or a single term, through a 3-stage pipe.
module dct_basis_streamer
    import dct_basis_streamer_pkg::*;
#(
    parameter int N        = DCT_N,
    parameter int COEF_W   = DCT_COEF_W,
    parameter int OUT_FRAC = DCT_OUT_FRAC,
    parameter int OUT_W    = DCT_OUT_W
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_mode,
    input  logic [$clog2(N)-1:0]   req_k1,
    input  logic [$clog2(N)-1:0]   req_k2,
    input  logic [$clog2(N)-1:0]   req_n1,
    input  logic [$clog2(N)-1:0]   req_n2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   out_n1,
    output logic [$clog2(N)-1:0]   out_n2,
    output logic                   out_last,
    output logic [OUT_W-1:0]       cos_term
);

    localparam int LN    = $clog2(N);
    localparam int PW    = 2 * COEF_W;
    localparam int SHIFT = 2 * (COEF_W - 2) - OUT_FRAC;
    localparam logic [PW-1:0] BIAS    = {{(PW-SHIFT){1'b0}}, {SHIFT{1'b1}}};
    localparam logic [LN-1:0] IDX_MAX = LN'(N - 1);

    state_t                state_r;
    logic                  mode_r;
    logic [LN-1:0]         k1_r, k2_r, n1_r, n2_r;
    logic                  stall_s, issue_s, last_issue_s;
    logic [COEF_W-1:0]     c1_s, c2_s;
    logic                  v1_r, last1_r, v2_r, last2_r;
    logic [LN-1:0]         n1_s1_r, n2_s1_r, n1_s2_r, n2_s2_r;
    logic signed [PW-1:0]  prod_s, p_r, sum_s, shifted_s;
    logic signed [OUT_W-1:0] term_s;

    assign stall_s      = out_valid && !out_ready;
    assign issue_s      = (state_r == ST_RUN) && !stall_s;
    assign last_issue_s = mode_r || ((n1_r == IDX_MAX) && (n2_r == IDX_MAX));

    assign prod_s    = PW'($signed(c1_s)) * PW'($signed(c2_s));
    // bias negative products so the arithmetic shift truncates toward zero
    assign sum_s     = p_r + (p_r[PW-1] ? BIAS : {PW{1'b0}});
    assign shifted_s = sum_s >>> SHIFT;
    assign term_s    = OUT_W'(shifted_s);

    dct_cos1d_rom #(.N(N), .COEF_W(COEF_W)) u_rom (
        .clk   (clk),
        .reset (reset),
        .rd_en (issue_s),
        .k1    (k1_r),
        .n1    (n1_r),
        .k2    (k2_r),
        .n2    (n2_r),
        .c1    (c1_s),
        .c2    (c2_s)
    );

    // request FSM and raster index counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b0;
            mode_r    <= 1'b0;
            k1_r      <= {LN{1'b0}};
            k2_r      <= {LN{1'b0}};
            n1_r      <= {LN{1'b0}};
            n2_r      <= {LN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        state_r   <= ST_RUN;
                        req_ready <= 1'b0;
                        mode_r    <= req_mode;
                        k1_r      <= req_k1;
                        k2_r      <= req_k2;
                        n1_r      <= req_mode ? req_n1 : {LN{1'b0}};
                        n2_r      <= req_mode ? req_n2 : {LN{1'b0}};
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        if (last_issue_s) begin
                            state_r <= ST_DRAIN;
                        end else if (n2_r == IDX_MAX) begin
                            n2_r <= {LN{1'b0}};
                            n1_r <= n1_r + LN'(1'b1);
                        end else begin
                            n2_r <= n2_r + LN'(1'b1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        state_r   <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    // pipeline registers; a stall freezes every stage together
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r      <= 1'b0;
            last1_r   <= 1'b0;
            n1_s1_r   <= {LN{1'b0}};
            n2_s1_r   <= {LN{1'b0}};
            v2_r      <= 1'b0;
            last2_r   <= 1'b0;
            n1_s2_r   <= {LN{1'b0}};
            n2_s2_r   <= {LN{1'b0}};
            p_r       <= {PW{1'b0}};
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_n1    <= {LN{1'b0}};
            out_n2    <= {LN{1'b0}};
            cos_term  <= {OUT_W{1'b0}};
        end else if (!stall_s) begin
            v1_r      <= issue_s;
            last1_r   <= issue_s && last_issue_s;
            n1_s1_r   <= n1_r;
            n2_s1_r   <= n2_r;
            v2_r      <= v1_r;
            last2_r   <= v1_r && last1_r;
            n1_s2_r   <= n1_s1_r;
            n2_s2_r   <= n2_s1_r;
            p_r       <= prod_s;
            out_valid <= v2_r;
            out_last  <= v2_r && last2_r;
            out_n1    <= n1_s2_r;
            out_n2    <= n2_s2_r;
            cos_term  <= term_s;
        end
    end

endmodule
